lsu: RTL and testbench

//  Load/store unit between the MEM pipeline stage and the word-addressed data memory.
//  - Turns LW/LH/LHU/LB/LBU/SW/SH/SB requests into word accesses.
//  - Loads: selects and sign-/zero-extends the addressed byte or halfword.
//  - SH/SB: read-modify-write over two memory cycles.
//  - Valid/ready handshake on both sides; one request in flight at a time.

---
 rtl/lsu.sv | 192 +++++++++++++++++++
 tb/tb_lsu.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// lsu: load/store unit between the MEM stage and a word-addressed data memory.
// Ports: lsu_clk, lsu_rst (async, active-high); request side lsu_req_valid/
//   lsu_req_ready/lsu_op/lsu_addr/lsu_wdata; response side lsu_resp_valid/
//   lsu_resp_ready/lsu_resp_data/lsu_resp_err; memory side mem_addr/mem_rd/
//   mem_wr/mem_wr_data/mem_rd_data.
// Build option: LSU_ALIGN_CHK_EN enables misalignment errors; without it the
//   low address bits are force-aligned and the access proceeds.
module lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  lsu_clk,
  input  logic                  lsu_rst,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [2:0]            lsu_op,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [31:0]           lsu_wdata,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic [31:0]           lsu_resp_data,
  output logic                  lsu_resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [31:0]           mem_wr_data,
  input  logic [31:0]           mem_rd_data
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    MERGE,
    RESP
  } state_t;

  state_t state, state_n;

  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           word_q;
  logic [31:0]           data_q;
  logic                  err_q;

  logic                  in_word;
  logic                  in_half;
  logic                  misal;
  logic [ADDR_WIDTH-1:0] addr_eff;

  assign in_word = (lsu_op == OP_LW) || (lsu_op == OP_SW);
  assign in_half = (lsu_op == OP_LH) || (lsu_op == OP_LHU) ||
                   (lsu_op == OP_SH);

`ifdef LSU_ALIGN_CHK_EN
  assign misal    = (in_word && (lsu_addr[1:0] != 2'b00)) ||
                    (in_half && lsu_addr[0]);
  assign addr_eff = lsu_addr;
`else
  assign misal = 1'b0;
  always_comb begin
    addr_eff = lsu_addr;
    if (in_word) addr_eff[1:0] = 2'b00;
    if (in_half) addr_eff[0] = 1'b0;
  end
`endif

  logic        half_q;
  logic        rmw_q;
  logic        load_q;
  logic [4:0]  sh;
  logic [15:0] lane;
  logic [31:0] load_val;
  logic [31:0] mask;
  logic [31:0] ins;
  logic [31:0] merged;

  assign half_q = (op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH);
  assign rmw_q  = (op_q == OP_SH) || (op_q == OP_SB);
  assign load_q = (op_q <= OP_LBU);

  // Bit position of the addressed lane within the word.
  always_comb begin
    if (BIG_ENDIAN) begin
      sh = half_q ? {~addr_q[1], 4'b0000} : {~addr_q[1:0], 3'b000};
    end else begin
      sh = half_q ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
    end
  end

  assign lane = 16'(mem_rd_data >> sh);

  always_comb begin
    load_val = mem_rd_data;
    unique case (op_q)
      OP_LH:   load_val = {{16{lane[15]}}, lane};
      OP_LHU:  load_val = {16'h0000, lane};
      OP_LB:   load_val = {{24{lane[7]}}, lane[7:0]};
      OP_LBU:  load_val = {24'h000000, lane[7:0]};
      default: load_val = mem_rd_data;
    endcase
  end

  assign mask   = half_q ? (32'h0000ffff << sh) : (32'h000000ff << sh);
  assign ins    = half_q ? ({16'h0000, wdata_q[15:0]} << sh)
                         : ({24'h000000, wdata_q[7:0]} << sh);
  assign merged = (word_q & ~mask) | (ins & mask);

  always_ff @(posedge lsu_clk or posedge lsu_rst) begin
    if (lsu_rst) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n        = state;
    lsu_req_ready  = 1'b0;
    lsu_resp_valid = 1'b0;
    mem_addr       = '0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    mem_wr_data    = 32'h0;
    unique case (state)
      IDLE: begin
        lsu_req_ready = ~lsu_rst;
        if (lsu_req_valid) state_n = misal ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        if (op_q == OP_SW) begin
          mem_wr      = 1'b1;
          mem_wr_data = wdata_q;
          state_n     = RESP;
        end else begin
          mem_rd  = 1'b1;
          state_n = rmw_q ? MERGE : RESP;
        end
      end
      MERGE: begin
        mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        mem_wr      = 1'b1;
        mem_wr_data = merged;
        state_n     = RESP;
      end
      RESP: begin
        lsu_resp_valid = 1'b1;
        if (lsu_resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge lsu_clk or posedge lsu_rst) begin
    if (lsu_rst) begin
      op_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (lsu_req_valid) begin
            op_q    <= lsu_op;
            addr_q  <= addr_eff;
            wdata_q <= lsu_wdata;
            err_q   <= misal;
            data_q  <= 32'h0;
          end
        end
        ACCESS: begin
          if (load_q) data_q <= load_val;
          if (rmw_q)  word_q <= mem_rd_data;
        end
        default: ;
      endcase
    end
  end

  assign lsu_resp_data = (state == RESP) ? data_q : 32'h0;
  assign lsu_resp_err  = (state == RESP) ? err_q : 1'b0;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized self-checking bench for lsu against a byte-level
// memory model; directed cases for reset abort, lanes, RMW and back-pressure.
module tb_lsu;

  localparam int AW = 32;
  localparam bit BE = 1'b1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    op;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_data;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [31:0]   mem_wr_data;
  logic [31:0]   mem_rd_data;

  always #5 clk = ~clk;

  lsu #(.ADDR_WIDTH(AW), .BIG_ENDIAN(BE)) dut (
    .lsu_clk(clk),
    .lsu_rst(rst),
    .lsu_req_valid(req_valid),
    .lsu_req_ready(req_ready),
    .lsu_op(op),
    .lsu_addr(addr),
    .lsu_wdata(wdata),
    .lsu_resp_valid(resp_valid),
    .lsu_resp_ready(resp_ready),
    .lsu_resp_data(resp_data),
    .lsu_resp_err(resp_err),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  logic [31:0] mem [0:255];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;
  int          clash = 0;

  assign mem_rd_data = mem_rd ? mem[mem_addr[9:2]] : 32'hxxxxxxxx;

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[9:2]] <= mem_wr_data;
    if (bd_we) mem[bd_idx] <= bd_data;
  end

  always @(negedge clk) if (mem_rd && mem_wr) clash++;

  logic [7:0] rb [0:1023];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rbyte(input int a);
    return rb[a & 1023];
  endfunction

  function automatic logic [31:0] ref_word(input int a);
    int b = a & ~3;
    if (BE) return {rbyte(b), rbyte(b+1), rbyte(b+2), rbyte(b+3)};
    return {rbyte(b+3), rbyte(b+2), rbyte(b+1), rbyte(b)};
  endfunction

  function automatic bit is_w(input logic [2:0] o);
    return o == 3'd0 || o == 3'd5;
  endfunction

  function automatic bit is_h(input logic [2:0] o);
    return o == 3'd1 || o == 3'd2 || o == 3'd6;
  endfunction

  function automatic bit ref_err(input logic [2:0] o, input int a);
`ifdef LSU_ALIGN_CHK_EN
    return (is_w(o) && (a % 4) != 0) || (is_h(o) && (a % 2) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int ref_ea(input logic [2:0] o, input int a);
`ifdef LSU_ALIGN_CHK_EN
    return a;
`else
    if (is_w(o)) return a - (a % 4);
    if (is_h(o)) return a - (a % 2);
    return a;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] o, input int a);
    logic [15:0] h;
    logic [7:0]  b;
    h = BE ? {rbyte(a), rbyte(a+1)} : {rbyte(a+1), rbyte(a)};
    b = rbyte(a);
    case (o)
      3'd0: return ref_word(a);
      3'd1: return {{16{h[15]}}, h};
      3'd2: return {16'h0, h};
      3'd3: return {{24{b[7]}}, b};
      3'd4: return {24'h0, b};
      default: return 32'h0;
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] o, input int a,
                           input logic [31:0] w);
    if (o == 3'd5) begin
      for (int k = 0; k < 4; k++)
        rb[(a + k) & 1023] = 8'(BE ? (w >> (8 * (3 - k))) : (w >> (8 * k)));
    end else if (o == 3'd6) begin
      rb[a & 1023]       = BE ? w[15:8] : w[7:0];
      rb[(a + 1) & 1023] = BE ? w[7:0] : w[15:8];
    end else if (o == 3'd7) begin
      rb[a & 1023] = w[7:0];
    end
  endtask

  task automatic set_word(input int a, input logic [31:0] w);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_idx  = 8'(a >> 2);
    bd_data = w;
    @(posedge clk);
    #1 bd_we = 1'b0;
    for (int k = 0; k < 4; k++)
      rb[(a & ~3) + k] = 8'(BE ? (w >> (8 * (3 - k))) : (w >> (8 * k)));
  endtask

  task automatic do_req(input logic [2:0] o, input int a,
                        input logic [31:0] wd, input int hold);
    int          ea, lat, nrd, nwr, t, xl, xr, xw;
    bit          er, busy, moved;
    logic [31:0] xd, d0;
    logic        e0;
    er = ref_err(o, a);
    ea = ref_ea(o, a);
    xd = (er || o >= 3'd5) ? 32'h0 : ref_load(o, ea);
    xl = er ? 1 : ((o == 3'd6 || o == 3'd7) ? 3 : 2);
    xr = (er || o == 3'd5) ? 0 : 1;
    xw = (er || o <= 3'd4) ? 0 : 1;
    @(negedge clk);
    req_valid = 1'b1;
    op        = o;
    addr      = AW'(a);
    wdata     = wd;
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    addr      = AW'($urandom);
    op        = 3'($urandom);
    lat = 1; nrd = 0; nwr = 0; busy = 0;
    while (!resp_valid && lat < 20) begin
      nrd += int'(mem_rd);
      nwr += int'(mem_wr);
      busy |= req_ready;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, xl);
    chk("rd_cycles", nrd, xr);
    chk("wr_cycles", nwr, xw);
    chk("resp_data", resp_data, xd);
    chk("resp_err", resp_err, er);
    d0 = resp_data;
    e0 = resp_err;
    moved = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      busy  |= req_ready;
      moved |= (resp_valid !== 1'b1) || (resp_data !== d0) ||
               (resp_err !== e0) || mem_rd || mem_wr;
    end
    chk("busy_ready", busy, 0);
    if (hold > 0) chk("resp_stable", moved, 0);
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("idle_after", {resp_valid, req_ready}, 2'b01);
    if (!er) ref_store(o, ea, wd);
    if (!er && o >= 3'd5) chk("mem_word", mem[ea >> 2], ref_word(ea));
  endtask

  int wrs;

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    op         = 3'd0;
    addr       = '0;
    wdata      = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {31'h0, |{req_ready, resp_valid, resp_data, resp_err,
        mem_addr, mem_rd, mem_wr, mem_wr_data}}, 0);
    for (int i = 0; i < 256; i++) set_word(i * 4, $urandom);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("ready_idle", req_ready, 1);

    set_word(32'h20, 32'hcafef00d);
    @(negedge clk);
    req_valid = 1'b1;
    op        = 3'd7;
    addr      = 32'h21;
    wdata     = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("sb_access_rd", mem_rd, 1);
    @(posedge clk);
    #1 chk("sb_merge_wr", mem_wr, 1);
    #2 rst = 1'b1;
    #1 chk("rst_mid_merge", {31'h0, |{req_ready, resp_valid, resp_data,
        resp_err, mem_addr, mem_rd, mem_wr, mem_wr_data}}, 0);
    wrs = 0;
    repeat (3) @(negedge clk) wrs += int'(mem_wr);
    rst = 1'b0;
    repeat (4) @(negedge clk) wrs += int'(mem_wr);
    chk("rst_no_wr", wrs, 0);
    chk("rst_word", mem[8], 32'hcafef00d);

    set_word(32'h40, 32'h8899aabb);
    do_req(3'd3, 32'h41, 0, 0);
    do_req(3'd4, 32'h41, 0, 0);
    do_req(3'd1, 32'h42, 0, 0);
    do_req(3'd2, 32'h42, 0, 0);
    do_req(3'd3, 32'h42, 0, 1);
    do_req(3'd4, 32'h40, 0, 1);
    do_req(3'd1, 32'h40, 0, 0);
    chk("lh42_const", ref_load(3'd1, 32'h42), 32'hffffaabb);

    set_word(32'h80, 32'h11223344);
    do_req(3'd7, 32'h83, 32'hffffffee, 0);
    chk("sb83_word", mem[32], 32'h112233ee);
    do_req(3'd6, 32'h80, 32'h0000beef, 0);

    do_req(3'd5, 32'h10, 32'hdeadbeef, 0);
    do_req(3'd0, 32'h10, 0, 0);
    chk("sw_lw_word", mem[4], 32'hdeadbeef);

    do_req(3'd0, 32'h06, 0, 0);
    do_req(3'd5, 32'h07, 32'h5555aaaa, 0);
    do_req(3'd2, 32'h09, 0, 0);

    do_req(3'd0, 32'h10, 0, 5);
    do_req(3'd7, 32'h33, 32'h000000a5, 5);

    for (int i = 0; i < 60; i++)
      do_req(3'($urandom_range(0, 7)), $urandom_range(0, 127),
             $urandom, $urandom_range(0, 3));

    chk("rd_wr_clash", clash, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
